// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types for the UART program loader.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (adds the CSUM state).
package prog_loader_pkg;

    // Loader states; PL_CSUM is only reachable when the checksum is built in.
    typedef enum logic [2:0] {
        PL_IDLE   = 3'd0,
        PL_LEN_HI = 3'd1,
        PL_LEN_LO = 3'd2,
        PL_DATA   = 3'd3,
        PL_CSUM   = 3'd4,
        PL_DONE   = 3'd5,
        PL_ERROR  = 3'd6
    } pl_state_t;

    // Error codes reported on the err port.
    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_FRAME   = 3'd1,
        ERR_TIMEOUT = 3'd2,
        ERR_LENGTH  = 3'd3,
        ERR_CSUM    = 3'd4
    } pl_err_t;

    // UART receiver states; RX_BREAK waits for the line to return high
    // after a stop bit that was sampled low.
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    // True in the states where a load is in progress.
    function automatic logic pl_is_busy(input pl_state_t s);
        return (s == PL_LEN_HI) || (s == PL_LEN_LO) || (s == PL_DATA) || (s == PL_CSUM);
    endfunction

endpackage

// File: rtl/prog_loader_uart_byte_rx.sv
// uart_byte_rx: 8N1 receiver with a 2-flop synchroniser, start-bit
// validation at mid-bit and mid-bit sampling of data and stop bits.
// byte_valid is a one-cycle pulse with no back-pressure; byte_data and
// frame_err are meaningful only in the cycle byte_valid is high.
module uart_byte_rx
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             rx_meta;
    logic             rx_sync;
    rx_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift, shift_next;
    logic             valid_next;

    // Two-flop synchroniser; idles high like the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // Receiver state, bit timing and registered byte outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_idx_next;
            shift      <= shift_next;
            byte_valid <= valid_next;
            frame_err  <= valid_next & ~rx_sync;
            if (valid_next) begin
                byte_data <= shift;
            end
        end
    end

    // Next-state logic: half a bit to the start-bit centre, then one bit per sample.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        valid_next   = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_next = '0;
                if (!rx_sync) begin
                    state_next = RX_START;
                end
            end
            RX_START: begin
                if (cnt == HALF_BIT) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (cnt == FULL_BIT) begin
                    cnt_next   = '0;
                    shift_next = {rx_sync, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = RX_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (cnt == FULL_BIT) begin
                    cnt_next   = '0;
                    valid_next = 1'b1;
                    state_next = rx_sync ? RX_IDLE : RX_BREAK;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            RX_BREAK: begin
                if (rx_sync) begin
                    state_next = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed UART byte stream, assembles
// DATA_W-bit words MSB first and writes them to sequential addresses.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds a trailing 8-bit
// checksum byte so that the sum of every byte from LEN_HI on is 0x00.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 12,
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              uart_rx,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              write,
    output logic              busy,
    output logic              done,
    output logic [2:0]        err,
    output logic [ADDR_W:0]   words_written
);

    localparam int BPW   = DATA_W / 8;
    localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam int CMP_W = (ADDR_W + 1 > 17) ? ADDR_W + 1 : 17;

    localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(BPW - 1);
    localparam logic [BC_W-1:0]   BC_ONE    = BC_W'(1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);
    localparam logic [ADDR_W:0]   WW_ONE    = (ADDR_W + 1)'(1);
    localparam logic [CMP_W-1:0]  MAX_WORDS = CMP_W'(1) << ADDR_W;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam pl_state_t AFTER_DATA = PL_CSUM;
`else
    localparam pl_state_t AFTER_DATA = PL_DONE;
`endif

    logic              byte_valid;
    logic [7:0]        rx_byte;
    logic              frame_err;

    pl_state_t         state, state_next;
    pl_err_t           err_q, err_next;
    logic [7:0]        len_hi, len_hi_next;
    logic [ADDR_W:0]   len_q, len_next;
    logic [DATA_W-1:0] asm_q, asm_next, asm_shift;
    logic [BC_W-1:0]   bcnt, bcnt_next;
    logic [TO_W-1:0]   idle_cnt, idle_next;
    logic [ADDR_W:0]   ww_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] data_next;
    logic              write_next;
    logic [CMP_W-1:0]  n_ext;
    logic              word_last;
    logic              timeout_hit;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_next, csum_sum;
`endif

    uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .byte_valid(byte_valid),
        .byte_data (rx_byte),
        .frame_err (frame_err)
    );

    assign busy = pl_is_busy(state);
    assign done = (state == PL_DONE);
    assign err  = err_q;

    // Loader state, assembler, counters and the registered memory write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= PL_IDLE;
            err_q         <= ERR_NONE;
            len_hi        <= '0;
            len_q         <= '0;
            asm_q         <= '0;
            bcnt          <= '0;
            idle_cnt      <= '0;
            words_written <= '0;
            address       <= '0;
            data          <= '0;
            write         <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            state         <= state_next;
            err_q         <= err_next;
            len_hi        <= len_hi_next;
            len_q         <= len_next;
            asm_q         <= asm_next;
            bcnt          <= bcnt_next;
            idle_cnt      <= idle_next;
            words_written <= ww_next;
            address       <= addr_next;
            data          <= data_next;
            write         <= write_next;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q        <= csum_next;
`endif
        end
    end

    // Next-state logic; priority: abort, frame error, byte, timeout, last word.
    always_comb begin
        state_next  = state;
        err_next    = err_q;
        len_hi_next = len_hi;
        len_next    = len_q;
        asm_next    = asm_q;
        bcnt_next   = bcnt;
        idle_next   = '0;
        ww_next     = words_written;
        addr_next   = address;
        data_next   = data;
        write_next  = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_next   = csum_q;
        csum_sum    = csum_q + rx_byte;
`endif
        n_ext       = CMP_W'({len_hi, rx_byte});
        asm_shift   = (asm_q << 8) | DATA_W'(rx_byte);
        word_last   = ((words_written + WW_ONE) == len_q);
        timeout_hit = ((state == PL_LEN_LO) || (state == PL_DATA) || (state == PL_CSUM))
                      && (idle_cnt == TO_LAST);

        // The idle counter runs between bytes once the header has started.
        if (busy && !byte_valid && (state != PL_LEN_HI)) begin
            idle_next = idle_cnt + TO_ONE;
        end

        // Word count follows the write strobe by one cycle.
        if (write) begin
            ww_next = words_written + WW_ONE;
        end

        case (state)
            PL_IDLE: begin
                err_next    = ERR_NONE;
                len_hi_next = '0;
                len_next    = '0;
                asm_next    = '0;
                bcnt_next   = '0;
                ww_next     = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum_next   = '0;
`endif
                if (enable) begin
                    state_next = PL_LEN_HI;
                end
            end
            PL_LEN_HI, PL_LEN_LO, PL_DATA, PL_CSUM: begin
                if (!enable) begin
                    state_next = PL_IDLE;
                    err_next   = ERR_NONE;
                end else if (byte_valid && frame_err) begin
                    state_next = PL_ERROR;
                    err_next   = ERR_FRAME;
                end else if (byte_valid) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_next = csum_sum;
`endif
                    case (state)
                        PL_LEN_HI: begin
                            len_hi_next = rx_byte;
                            state_next  = PL_LEN_LO;
                        end
                        PL_LEN_LO: begin
                            if (n_ext > MAX_WORDS) begin
                                state_next = PL_ERROR;
                                err_next   = ERR_LENGTH;
                            end else if (n_ext == '0) begin
                                state_next = AFTER_DATA;
                            end else begin
                                len_next   = n_ext[ADDR_W:0];
                                state_next = PL_DATA;
                            end
                        end
                        PL_DATA: begin
                            asm_next = asm_shift;
                            if (bcnt == BC_LAST) begin
                                bcnt_next  = '0;
                                write_next = 1'b1;
                                addr_next  = words_written[ADDR_W-1:0];
                                data_next  = asm_shift;
                            end else begin
                                bcnt_next = bcnt + BC_ONE;
                            end
                        end
                        default: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            if (csum_sum == 8'h00) begin
                                state_next = PL_DONE;
                            end else begin
                                state_next = PL_ERROR;
                                err_next   = ERR_CSUM;
                            end
`else
                            state_next = PL_DONE;
`endif
                        end
                    endcase
                end else if (timeout_hit) begin
                    state_next = PL_ERROR;
                    err_next   = ERR_TIMEOUT;
                end else if ((state == PL_DATA) && write && word_last) begin
                    state_next = AFTER_DATA;
                end
            end
            PL_DONE, PL_ERROR: begin
                if (!enable) begin
                    state_next = PL_IDLE;
                    err_next   = ERR_NONE;
                end
            end
            default: state_next = PL_IDLE;
        endcase
    end

endmodule
